// File: rtl/sonic_common_logic_vector_catch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sonic_common_logic_vector_catch_buffer
// Description : Credit-gated catch buffer (FWFT FIFO) for a fixed-latency pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module sonic_common_logic_vector_catch_buffer #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic                         arr_valid,
    input  logic [WIDTH-1:0]             arr_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         overflow
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PONE  = c_PTR_W'(1);

    logic [c_CNT_W-1:0] r_credits;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_overflow;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic w_issue_fire;
    logic w_pop;
    logic w_full;
    logic w_write;

    assign issue_ready  = (r_credits != '0);
    assign out_valid    = (r_count != '0);
    assign out_data     = r_mem[r_rd_ptr];
    assign fill_level   = r_count;
    assign overflow     = r_overflow;

    assign w_issue_fire = issue_valid && issue_ready;
    assign w_pop        = out_valid && out_ready;
    // Full is judged on the pre-edge level, so a pop cannot make room for
    // an arrival landing in the same cycle.
    assign w_full       = (r_count == c_DEPTH);
    assign w_write      = arr_valid && !w_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_credits <= c_DEPTH;
        end else if (w_issue_fire && !w_pop) begin
            r_credits <= r_credits - c_ONE;
        end else if (w_pop && !w_issue_fire && (r_credits != c_DEPTH)) begin
            r_credits <= r_credits + c_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (arr_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; the count gates visibility.
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= arr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sonic_common_logic_vector_catch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sonic_common_logic_vector_catch_buffer
// Description : Self-checking bench: directed tables, sequences, random+model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonic_common_logic_vector_catch_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_ready, arr_valid, out_valid, out_ready, overflow;
    logic [7:0] arr_data, out_data;
    logic [2:0] fill_level;

    logic       i3_valid, i3_ready, a3_valid, o3_valid, o3_ready, ovf3;
    logic [7:0] a3_data, o3_data;
    logic [1:0] fill3;

    int         checks = 0;
    int         errors = 0;
    logic       chk_en = 1'b0;
    int         arr_mode;
    logic [7:0] seq_base;
    logic       d_valid;
    logic [7:0] d_data;
    logic [1:0] pv;
    logic [7:0] pd0, pd1;
    int         n_fired;

    logic [7:0] m_q[$];
    int         m_credits;
    logic       m_ovf;

    always #5 clk = ~clk;

    sonic_common_logic_vector_catch_buffer #(.WIDTH(8), .DEPTH(DEPTH)) u_dut (
        .clock(clk), .reset_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .arr_valid(arr_valid), .arr_data(arr_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fill_level(fill_level), .overflow(overflow)
    );

    sonic_common_logic_vector_catch_buffer #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clock(clk), .reset_n(rst_n),
        .issue_valid(i3_valid), .issue_ready(i3_ready),
        .arr_valid(a3_valid), .arr_data(a3_data),
        .out_valid(o3_valid), .out_data(o3_data), .out_ready(o3_ready),
        .fill_level(fill3), .overflow(ovf3)
    );

    // Zero-latency launch path for the DEPTH=3 instance.
    assign a3_valid = i3_valid && i3_ready;

    // Delay line: word launched before edge e is seen by the buffer at edge
    // e+2 and is visible at its output three cycles after it was issued.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv      <= '0;
            pd0     <= '0;
            pd1     <= '0;
            n_fired <= 0;
        end else begin
            pv[0] <= issue_valid && issue_ready;
            pd0   <= seq_base + n_fired[7:0];
            pv[1] <= pv[0];
            pd1   <= pd0;
            if (issue_valid && issue_ready) n_fired <= n_fired + 1;
        end
    end

    always_comb begin
        arr_valid = 1'b0;
        arr_data  = 8'h00;
        case (arr_mode)
            0: begin arr_valid = pv[1]; arr_data = pd1; end
            1: begin arr_valid = d_valid; arr_data = d_data; end
            default: begin
                arr_valid = issue_valid && issue_ready;
                arr_data  = seq_base + n_fired[7:0];
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue plus a credit count bounded to 0..DEPTH.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_credits <= DEPTH;
            m_ovf     <= 1'b0;
        end else begin
            automatic int   sz   = m_q.size();
            automatic logic pop  = (sz != 0) && out_ready;
            automatic logic fire = issue_valid && (m_credits > 0);
            if (arr_valid && sz == DEPTH) m_ovf <= 1'b1;
            if (pop) void'(m_q.pop_front());
            if (arr_valid && sz < DEPTH) m_q.push_back(arr_data);
            if (fire && !pop) m_credits <= m_credits - 1;
            else if (pop && !fire && m_credits < DEPTH) m_credits <= m_credits + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("m_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
            check("m_fill", {29'd0, fill_level}, m_q.size());
            check("m_ready", {31'd0, issue_ready}, {31'd0, m_credits != 0});
            check("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
            if (m_q.size() != 0) check("m_data", {24'd0, out_data}, {24'd0, m_q[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       ordy;
        logic       e_valid;
        logic [7:0] e_data;
        logic [2:0] e_fill;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int exp_word, bad_ready, max_fill;

        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 3'd1, 1'b0};
        tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 3'd2, 1'b0};
        tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 3'd3, 1'b0};
        tbl[3]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 3'd4, 1'b0};
        tbl[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA1, 3'd4, 1'b1};
        tbl[5]  = '{1'b1, 8'hA6, 1'b1, 1'b1, 8'hA2, 3'd3, 1'b1};
        tbl[6]  = '{1'b1, 8'hA7, 1'b1, 1'b1, 8'hA3, 3'd3, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 3'd2, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA7, 3'd1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};

        rst_n = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
        arr_mode = 0; seq_base = 8'h00; d_valid = 1'b0; d_data = 8'h00;
        i3_valid = 1'b0; o3_ready = 1'b0; a3_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fill", {29'd0, fill_level}, 32'd0);
        check("rst_ready", {31'd0, issue_ready}, 32'd1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Fill to stall, then drain.
        do_reset();
        seq_base = 8'h01; arr_mode = 0; out_ready = 1'b0; issue_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            check("stall_ready", {31'd0, issue_ready}, {31'd0, k <= 4});
            tick();
        end
        check("stall_issues", n_fired, 32'd4);
        check("stall_fill", {29'd0, fill_level}, 32'd4);
        check("stall_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("drain_data", {24'd0, out_data}, j + 1);
            check("drain_ready", {31'd0, issue_ready}, {31'd0, j != 0});
            tick();
        end
        issue_valid = 1'b0; out_ready = 1'b0;
        repeat (6) tick();

        // Streaming 100 words.
        do_reset();
        seq_base = 8'h00; issue_valid = 1'b1; out_ready = 1'b1;
        exp_word = 0; bad_ready = 0; max_fill = 0;
        for (int c = 0; c < 400 && exp_word < 100; c++) begin
            issue_valid = (n_fired < 100);
            if (!issue_ready && n_fired < 100) bad_ready++;
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            if (out_valid) begin
                check("stream_data", {24'd0, out_data}, exp_word);
                exp_word++;
            end
            tick();
        end
        check("stream_count", exp_word, 32'd100);
        check("stream_ready_drops", bad_ready, 32'd0);
        check("stream_fill_le_depth", {31'd0, max_fill <= DEPTH}, 32'd1);
        issue_valid = 1'b0; out_ready = 1'b0;

        // Forced overflow and full+pop table.
        do_reset();
        arr_mode = 1;
        for (int i = 0; i < 11; i++) begin
            d_valid = tbl[i].av; d_data = tbl[i].ad; out_ready = tbl[i].ordy;
            tick();
            check("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) check("tbl_data", {24'd0, out_data}, {24'd0, tbl[i].e_data});
            check("tbl_fill", {29'd0, fill_level}, {29'd0, tbl[i].e_fill});
            check("tbl_ovf", {31'd0, overflow}, {31'd0, tbl[i].e_ovf});
        end
        d_valid = 1'b0; out_ready = 1'b0;

        // Asynchronous reset with two words stored.
        do_reset();
        d_valid = 1'b1; d_data = 8'h55; tick();
        d_data = 8'h66; tick();
        d_valid = 1'b0;
        check("pre_rst_fill", {29'd0, fill_level}, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_fill", {29'd0, fill_level}, 32'd0);
        check("async_ready", {31'd0, issue_ready}, 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Wrap on the DEPTH=3 instance.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            i3_valid = 1'b1; a3_data = 8'h30 + 8'(k); o3_ready = 1'b0;
            tick();
            i3_valid = 1'b0;
            check("wrap_valid", {31'd0, o3_valid}, 32'd1);
            check("wrap_data", {24'd0, o3_data}, 32'h30 + k);
            check("wrap_fill1", {30'd0, fill3}, 32'd1);
            o3_ready = 1'b1;
            tick();
            check("wrap_fill0", {30'd0, fill3}, 32'd0);
        end
        o3_ready = 1'b0;
        check("wrap_ovf", {31'd0, ovf3}, 32'd0);
        check("wrap_ready", {31'd0, i3_ready}, 32'd1);

        // Random traffic through the delay line.
        do_reset();
        arr_mode = 0; seq_base = 8'h80;
        for (int c = 0; c < 1500; c++) begin
            issue_valid = ($urandom_range(3) != 0);
            out_ready   = ($urandom_range(2) != 0);
            tick();
        end
        // Random direct arrivals with a slow sink to provoke overflows.
        arr_mode = 1;
        for (int c = 0; c < 600; c++) begin
            issue_valid = ($urandom_range(1) != 0);
            d_valid     = ($urandom_range(1) != 0);
            d_data      = 8'($urandom);
            out_ready   = ($urandom_range(3) == 0);
            tick();
        end
        d_valid = 1'b0;
        // Zero-latency launch path with occasional mid-run resets.
        do_reset();
        arr_mode = 2;
        for (int c = 0; c < 600; c++) begin
            issue_valid = ($urandom_range(3) != 0);
            out_ready   = ($urandom_range(2) != 0);
            if (c % 150 == 149) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        issue_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sonic_common_logic_vector_catch_buffer.md
SONIC_COMMON_LOGIC_VECTOR_CATCH_BUFFER -- requirements
Module: sonic_common_logic_vector_catch_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, which sets the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, which sets the number of storage entries (legal range 1..256, not restricted to powers of two).
REQ-003 Port clock, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous active-low reset; assertion SHALL act immediately and deassertion SHALL be sampled on clock.
REQ-005 Port issue_valid, input, 1 bit: the source requests to launch one word into the fixed-latency delay pipeline.
REQ-006 Port issue_ready, output, 1 bit: grants the launch; high iff credits != 0.
REQ-007 Port arr_valid, input, 1 bit: a word is arriving from the delay-pipeline output.
REQ-008 Port arr_data, input, WIDTH bits: the arriving word.
REQ-009 Port out_valid, output, 1 bit: the buffer is non-empty.
REQ-010 Port out_data, output, WIDTH bits: the head-of-buffer word (first-word fall-through).
REQ-011 Port out_ready, input, 1 bit: the sink accepts the head word.
REQ-012 Port fill_level, output, clog2(DEPTH+1) bits: the current occupancy.
REQ-013 Port overflow, output, 1 bit: sticky protocol-violation flag.

Function
REQ-014 issue_fire SHALL be defined as issue_valid && issue_ready; pop SHALL be defined as out_valid && out_ready.
REQ-015 credits SHALL be an internal counter with range 0..DEPTH.
REQ-016 credits SHALL decrement by 1 on issue_fire alone, increment by 1 on pop alone, and stay unchanged when both occur.
REQ-017 credits SHALL never exceed DEPTH nor fall below 0.
REQ-018 issue_ready SHALL be combinational from credits only and SHALL NOT depend on issue_valid.
REQ-019 The block SHALL NOT depend on the pipeline latency; any latency >= 0 cycles SHALL be supported.
REQ-020 Write: arr_valid with fill_level < DEPTH SHALL store arr_data at the write pointer and advance the pointer.
REQ-021 An arrival SHALL raise out_valid on the next cycle (write-to-read latency of 1 cycle); there SHALL be no combinational path from arr_* to out_*.
REQ-022 Pop SHALL advance the read pointer, and out_data SHALL present the next entry in the cycle after the pop.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 fill_level SHALL change by +1 on write only, -1 on pop only, and 0 on write+pop in the same cycle.
REQ-025 When empty: out_valid=0; out_ready SHALL be ignored; out_data is don't-care.
REQ-026 Simultaneous arrival and pop when fill_level=DEPTH: the pop SHALL complete, and the arrival SHALL be dropped and set overflow (full is evaluated on the pre-edge level).
REQ-027 Arrival when fill_level=DEPTH SHALL drop the word, leave all pointers unchanged, and set overflow=1 until reset.
REQ-028 Order SHALL be strictly preserved (FIFO); data SHALL be neither duplicated nor reordered.
REQ-029 Simultaneous issue_fire, arrival and pop SHALL all take effect in the same cycle.

Reset
REQ-030 While reset_n=0: credits=DEPTH, both pointers=0, fill_level=0, out_valid=0, overflow=0, issue_ready=1.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 A mid-operation reset SHALL discard stored and in-flight words; the delay pipeline SHALL be reset by the same reset_n.
REQ-033 Outputs SHALL take their reset values in the same cycle that reset_n falls (asynchronous).

Verification
REQ-034 Fill-to-stall (WIDTH=8, DEPTH=4, 3-cycle delay line, out_ready=0, issue_valid=1) -> exactly 4 issues; issue_ready=0 from the 5th cycle on; 0x01..0x04 stored; fill_level=4; overflow=0.
REQ-035 Drain after stall (same setup, then out_ready=1) -> out_data 0x01,0x02,0x03,0x04 on consecutive cycles; issue_ready rises the cycle after the first pop.
REQ-036 Streaming (issue_valid=1 and out_ready=1 continuously, 100 words) -> issue_ready never drops, output order 0..99, fill_level <= 4.
REQ-037 Forced overflow (arr_valid driven directly 5 times with out_ready=0) -> 5th word dropped, overflow=1, fill_level=4, head=first word.
REQ-038 Wrap (DEPTH=3, 10 single-word issue/pop cycles) -> pointers wrap; data intact; fill_level returns to 0.
REQ-039 Reset with fill_level=2 -> out_valid=0, fill_level=0 and issue_ready=1 immediately, before the next clock edge.
